// File: rtl/seven_seg_display_arbiter_pkg.sv
// Shared types and constants for the two-client seven-segment display arbiter.
package seven_seg_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int BUF_W      = DIGIT_W * NUM_DIGITS;

  // Encoding chosen so that the state value equals the one-hot grant.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [BUF_W-1:0] BLANK_BUF = 16'h0000;
  localparam logic [2:0]       BLANK_DP  = 3'd0;
  localparam logic [3:0]       BLANK_LUM = 4'd0;

endpackage

// File: rtl/seven_seg_display_arbiter_dwell_timer.sv
// Saturating dwell counter: counts cycles of ownership and flags when the
// minimum hold time has been served.
module dwell_timer #(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);

  logic [CNT_W-1:0] count;

  assign done = (count == CNT_W'(DWELL_CYCLES));

  // Clear has priority; otherwise count up while enabled and stop at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seven_seg_display_arbiter.sv
// Two-client arbiter for a shared seven-segment display. The owner's digits,
// decimal point and brightness are forwarded (registered) to the driver.
//
// Handshake: a client raises req and must keep buf/dp/lum valid for as long
// as req is high. gnt[n] (registered, one cycle after req is sampled) means
// client n owns the display; the client releases by dropping req. An owner
// holding req may be preempted by the other client only after it has held
// the display for DWELL_CYCLES cycles.
module seven_seg_display_arbiter
  import seven_seg_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [BUF_W-1:0] buf0,
  input  logic [2:0]       dp0,
  input  logic [3:0]       lum0,
  input  logic             req1,
  input  logic [BUF_W-1:0] buf1,
  input  logic [2:0]       dp1,
  input  logic [3:0]       lum1,
  output logic [1:0]       gnt,
  output logic [BUF_W-1:0] disp_buf,
  output logic [2:0]       dp,
  output logic [3:0]       lum,
  output state_t           dbg_state
);

  state_t state;
  state_t next_state;
  logic   last_owner;
  logic   dwell_done;
  logic   grant_change;

  assign dbg_state    = state;
  assign grant_change = (next_state != state);

  // Counter restarts on any state change and runs only while someone owns.
  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (grant_change),
    .enable(state != IDLE),
    .done  (dwell_done)
  );

  // Next-state arbitration: release is immediate, preemption waits for dwell.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  next_state = last_owner ? OWN0 : OWN1;
        else if (req0)     next_state = OWN0;
        else if (req1)     next_state = OWN1;
        else               next_state = IDLE;
      end
      OWN0: begin
        if (!req0)                     next_state = req1 ? OWN1 : IDLE;
        else if (req1 && dwell_done)   next_state = OWN1;
        else                           next_state = OWN0;
      end
      OWN1: begin
        if (!req1)                     next_state = req0 ? OWN0 : IDLE;
        else if (req0 && dwell_done)   next_state = OWN0;
        else                           next_state = OWN1;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, grant, last owner and the display data all register together so
  // the data seen by the driver is always that of the current grant holder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      disp_buf   <= BLANK_BUF;
      dp         <= BLANK_DP;
      lum        <= BLANK_LUM;
      last_owner <= 1'b1;
    end else begin
      state <= next_state;
      gnt   <= next_state;
      case (next_state)
        OWN0: begin
          disp_buf <= buf0;
          dp       <= dp0;
          lum      <= lum0;
        end
        OWN1: begin
          disp_buf <= buf1;
          dp       <= dp1;
          lum      <= lum1;
        end
        default: begin
          disp_buf <= BLANK_BUF;
          dp       <= BLANK_DP;
          lum      <= BLANK_LUM;
        end
      endcase
      if (grant_change && next_state != IDLE) begin
        last_owner <= (next_state == OWN1);
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Directed bench for seven_seg_display_arbiter with a short dwell time.
module tb_seven_seg_display_arbiter;
  import seven_seg_pkg::*;

  localparam int DWELL = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] buf0 = '0, buf1 = '0;
  logic [2:0]  dp0 = '0, dp1 = '0;
  logic [3:0]  lum0 = '0, lum1 = '0;
  logic [1:0]  gnt;
  logic [15:0] disp_buf;
  logic [2:0]  dp;
  logic [3:0]  lum;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  seven_seg_display_arbiter #(
    .DWELL_CYCLES(DWELL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .buf0     (buf0),
    .dp0      (dp0),
    .lum0     (lum0),
    .req1     (req1),
    .buf1     (buf1),
    .dp1      (dp1),
    .lum1     (lum1),
    .gnt      (gnt),
    .disp_buf (disp_buf),
    .dp       (dp),
    .lum      (lum),
    .dbg_state(dbg_state)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] e_gnt,
                           input logic [15:0] e_buf, input logic [2:0] e_dp,
                           input logic [3:0] e_lum);
    check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    check({tag, ".buf"}, 32'(disp_buf), 32'(e_buf));
    check({tag, ".dp"}, 32'(dp), 32'(e_dp));
    check({tag, ".lum"}, 32'(lum), 32'(e_lum));
  endtask

  initial begin
    // reset for two cycles
    rst = 1'b1;
    step();
    step();
    check_out("reset", 2'b00, 16'h0000, 3'd0, 4'd0);
    check("reset.state", 32'(dbg_state), 32'(IDLE));

    // single request from client 0
    rst = 1'b0;
    req0 = 1'b1; buf0 = 16'h1234; lum0 = 4'd9; dp0 = 3'd0;
    step();
    check_out("grant0", 2'b01, 16'h1234, 3'd0, 4'd9);
    check("grant0.state", 32'(dbg_state), 32'(OWN0));

    // owner data tracks inputs with one cycle of latency
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      buf0 = 16'(16'h5000 + $urandom_range(0, 16'h0fff));
      dp0  = 3'd5 + 3'(i % 3);
      exp_q.push_back(buf0);
      step();
      check("track.buf", 32'(disp_buf), 32'(exp_q.pop_front()));
      check("track.dp", 32'(dp), 32'(3'd5 + 3'(i % 3)));
    end

    // release to idle blanks outputs; tie then goes to client 1
    req0 = 1'b0;
    step();
    check_out("release", 2'b00, 16'h0000, 3'd0, 4'd0);
    req0 = 1'b1; buf0 = 16'h0404; dp0 = 3'd1; lum0 = 4'd3;
    req1 = 1'b1; buf1 = 16'hABCD; dp1 = 3'd7; lum1 = 4'd15;
    step();
    check_out("tie1", 2'b10, 16'hABCD, 3'd7, 4'd15);

    // constant contention: five cycles each, alternating
    for (int i = 0; i < 4; i++) begin
      step();
      check("cont.own1a", 32'(gnt), 32'(2'b10));
    end
    for (int i = 0; i < 5; i++) begin
      step();
      check("cont.own0", 32'(gnt), 32'(2'b01));
      if (i == 0) check("cont.own0.buf", 32'(disp_buf), 32'(16'h0404));
    end
    for (int i = 0; i < 5; i++) begin
      step();
      check("cont.own1b", 32'(gnt), 32'(2'b10));
    end

    // owner 1 drops early in dwell while client 0 waits
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("idle2", 32'(gnt), 32'(2'b00));
    req1 = 1'b1;
    step();
    check("own1.only", 32'(gnt), 32'(2'b10));
    req0 = 1'b1; buf0 = 16'h7788;
    step();
    step();
    check("own1.hold", 32'(gnt), 32'(2'b10));
    req1 = 1'b0;
    step();
    check_out("early", 2'b01, 16'h7788, 3'd1, 4'd3);

    // both drop exactly when a switch would happen
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("dwell0", 32'(gnt), 32'(2'b01));
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    check_out("bothdrop", 2'b00, 16'h0000, 3'd0, 4'd0);

    // reset in the middle of an OWN1 grant
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("own1.pre", 32'(gnt), 32'(2'b10));
    for (int i = 0; i < 3; i++) step();
    check("own1.c3", 32'(gnt), 32'(2'b10));
    rst = 1'b1;
    step();
    check_out("midrst", 2'b00, 16'h0000, 3'd0, 4'd0);
    rst = 1'b0;
    step();
    check_out("postrst", 2'b01, 16'h7788, 3'd1, 4'd3);

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_display_arbiter.md
SEVEN_SEG_DISPLAY_ARBITER -- requirements
Module: seven_seg_display_arbiter

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 50_000_000, giving the minimum grant hold in clk cycles before preemption; it is legal from 1 upward and is reduced in simulation.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 The block SHALL have port req0, input, 1, the request from client 0.
REQ-005 The block SHALL have port buf0, input, 16, client 0's four packed digits, [15:12] leftmost.
REQ-006 The block SHALL have port dp0, input, 3, client 0's decimal-point position (0 = none, 1..4 = digit).
REQ-007 The block SHALL have port lum0, input, 4, client 0's brightness, 0..15.
REQ-008 The block SHALL have ports req1, buf1, dp1 and lum1, identical to client 0's ports but for client 1.
REQ-009 The block SHALL have port gnt, output, 2, one-hot grant where bit n means client n owns the display; 2'b00 means idle.
REQ-010 The block SHALL have port disp_buf, output, 16, the display buffer to the display driver.
REQ-011 The block SHALL have port dp, output, 3, the decimal point to the display driver.
REQ-012 The block SHALL have port lum, output, 4, the brightness to the display driver.

Function
REQ-013 The state machine SHALL have three states:
- IDLE: gnt=00.
- OWN0: gnt=01.
- OWN1: gnt=10.
REQ-014 A register last_owner (1 bit) SHALL record the most recently granted client; gnt, disp_buf, dp, lum and last_owner SHALL all be registered.
REQ-015 In IDLE, the next state SHALL be:
- OWN0 if only req0 is high.
- OWN1 if only req1 is high.
- The client != last_owner if both are high.
- IDLE if neither is high.
REQ-016 In OWNn with req_n low, the next state SHALL be OWN(other) if the other client's req is high, else IDLE; release ignores the dwell count.
REQ-017 In OWNn with req_n high, the next state SHALL be OWN(other) only when the other client's req is high and dwell_done=1; otherwise it SHALL stay OWNn.
REQ-018 Dwell counter:
- Width SHALL be $clog2(DWELL_CYCLES+1).
- It SHALL clear to 0 on every cycle the next state is a new grant.
- It SHALL increment each cycle in OWNn and saturate at DWELL_CYCLES.
- dwell_done SHALL equal (count == DWELL_CYCLES).
- It SHALL hold 0 in IDLE.
REQ-019 Latency: a request sampled at edge k SHALL produce gnt at edge k+1, with no combinational path from req to gnt.
REQ-020 Data path: on each edge, disp_buf, dp and lum SHALL load the inputs of the client selected by the next state, so data is aligned with gnt and tracks the owner's inputs with one cycle of latency.
REQ-021 When the next state is IDLE, the outputs SHALL load blank: disp_buf=16'h0000, dp=3'd0, lum=4'd0.
REQ-022 A client SHALL drive its buf/dp/lum valid whenever its req is high; the block SHALL not validate dp (values 5..7 pass through unchanged).
REQ-023 On a grant change, last_owner SHALL load the new owner's index; it SHALL not change on entry to IDLE.
REQ-024 If both clients drop req in the same cycle as a switch would occur, the next state SHALL be IDLE.
REQ-025 With DWELL_CYCLES=1, under constant contention the grant SHALL alternate: 1 cycle OWNn (count 0), then 1 cycle in which count reaches 1, then switch, giving a 2-cycle period.

Reset
REQ-026 While rst=1 at an edge, the block SHALL load:
- state=IDLE, gnt=00.
- disp_buf=16'h0000, dp=0, lum=0.
- dwell count=0.
- last_owner=1, so that client 0 wins the first tie.
REQ-027 Reset SHALL override everything, including mid-grant; the first grant SHALL be possible at the edge after the first edge with rst=0.

Structure
REQ-028 A shared package seven_seg_pkg SHALL hold:
- The state encoding (IDLE/OWN0/OWN1).
- Constants BLANK_BUF=16'h0000, BLANK_DP=3'd0, BLANK_LUM=4'd0.
- DIGIT_W=4 and NUM_DIGITS=4.
REQ-029 The block SHALL have one sub-module, dwell_timer (parameter DWELL_CYCLES; inputs clk, rst, clear, enable; output done), which holds the saturating counter.
REQ-030 Outputs SHALL connect directly to the display driver's disp_buf/dp/lum inputs with no further logic.

Verification
REQ-031 With DWELL_CYCLES=4: rst for 2 cycles, then req0=1, buf0=16'h1234, lum0=9 -> one edge later gnt=01, disp_buf=16'h1234, lum=9, dp=0.
REQ-032 With DWELL_CYCLES=4: out of reset, assert req0 and req1 together -> gnt=01 first; keep both high -> gnt stays 01 for exactly 5 cycles, then 10 for 5 cycles, alternating.
REQ-033 With DWELL_CYCLES=4: OWN1 with req1 high, then drop req1 at cycle 2 of dwell while req0=1 -> gnt=01 on the next edge with disp_buf=buf0, ignoring dwell.
REQ-034 With DWELL_CYCLES=4: OWN0 with req0 dropped and req1=0 -> gnt=00, disp_buf=0000, lum=0, dp=0; then both req high -> gnt=10, since last_owner=0.
REQ-035 With DWELL_CYCLES=4: assert rst during OWN1 with count=3 -> next edge gnt=00 and outputs blank; release rst with both req high -> gnt=01.
REQ-036 With DWELL_CYCLES=4: change buf0 every cycle while in OWN0 -> disp_buf equals buf0 delayed exactly one cycle.
